task_frame_scheduler: RTL

//  Round-robin scheduler sharing one upstream stream source (tdata/valid/last) between N task input buffers.
//  A task raises its request bit when it wants a new frame; the scheduler grants one task, opens a tready window and

---
 rtl/task_frame_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/task_frame_scheduler.sv
// Round-robin frame scheduler: shares one upstream stream between N_TASKS task buffers,
// one whole frame per grant, with a per-frame word limit that truncates and flushes overlong frames.
module task_frame_scheduler #(
  parameter int N_TASKS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 243
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_TASKS-1:0]             i_req,
  input  logic                           i_tdata_valid,
  input  logic [DATA_WIDTH-1:0]          i_tdata,
  input  logic                           i_tdata_last,
  output logic                           o_tready,
  output logic [DATA_WIDTH-1:0]          o_tdata,
  output logic [N_TASKS-1:0]             o_tdata_valid,
  output logic [N_TASKS-1:0]             o_tdata_last,
  output logic [N_TASKS-1:0]             o_grant,
  output logic                           o_frame_done,
  output logic                           o_err,
  output logic [$clog2(MAX_WORDS+1)-1:0] o_word_cnt,
  output logic [1:0]                     o_state
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int PW = $clog2(N_TASKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               state, state_d;
  logic                 tready_d, done_d, err_d;
  logic [N_TASKS-1:0]   grant_d, win_oh;
  logic [PW-1:0]        ptr, ptr_d, win_idx, idx;
  logic [PW:0]          sum;
  logic [CW-1:0]        cnt_d;
  logic                 found, beat, xfer_beat, at_limit;

  // Handshake: an upstream beat transfers on a cycle where i_tdata_valid and o_tready are both high;
  // i_tdata_last only has meaning on such a cycle. Task strobes are single-cycle write enables.
  assign beat      = i_tdata_valid & o_tready;
  assign xfer_beat = beat && (state == S_XFER);
  assign at_limit  = (o_word_cnt == CW'(MAX_WORDS - 1));

  assign o_tdata       = i_tdata;
  assign o_tdata_valid = xfer_beat ? o_grant : '0;
  assign o_tdata_last  = (xfer_beat && (i_tdata_last || at_limit)) ? o_grant : '0;
  assign o_state       = state;

  // Search from ptr+1 upward, wrapping, so the previous winner has lowest priority.
  always_comb begin
    win_idx = ptr;
    win_oh  = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 1; i <= N_TASKS; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_TASKS)) sum = sum - (PW+1)'(N_TASKS);
      idx = sum[PW-1:0];
      if (!found && i_req[idx]) begin
        found       = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state;
    tready_d = o_tready;
    grant_d  = o_grant;
    ptr_d    = ptr;
    cnt_d    = o_word_cnt;
    done_d   = 1'b0;
    err_d    = o_err;
    case (state)
      S_IDLE: begin
        tready_d = 1'b0;
        if (found) begin
          grant_d = win_oh;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        tready_d = 1'b1;
        state_d  = S_XFER;
      end
      S_XFER: begin
        if (beat) begin
          cnt_d = o_word_cnt + 1'b1;
          if (i_tdata_last) begin
            tready_d = 1'b0;
            grant_d  = '0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else if (at_limit) begin
            // Truncate for the task; tready stays up so the tail is drained upstream.
            err_d   = 1'b1;
            grant_d = '0;
            done_d  = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        tready_d = 1'b1;
        if (beat && i_tdata_last) begin
          tready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        tready_d = 1'b0;
        grant_d  = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_tready     <= 1'b0;
      o_grant      <= '0;
      ptr          <= PW'(N_TASKS - 1);
      o_word_cnt   <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_d;
      o_tready     <= tready_d;
      o_grant      <= grant_d;
      ptr          <= ptr_d;
      o_word_cnt   <= cnt_d;
      o_frame_done <= done_d;
      o_err        <= err_d;
    end
  end

endmodule
